// File: rtl/fib_datapath.sv
// Register file plus single-cycle ALU executing Fibonacci FSM control words.
// Operands read combinationally; results and {C,Z,N,V} flags commit on enabled edges.
module fib_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [7:0]       alu_op,
  input  logic [7:0]       muxes,
  input  logic [NREGS-1:0] regs_en,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_MOV = 4'd8,
    OP_CMP = 4'd9
  } op_e;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] r_q [NREGS];
  logic [WIDTH-1:0] r_d [NREGS];
  logic [3:0]       flags_q, flags_d;

  logic [3:0]       opcode;
  logic             imm_sel;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [WIDTH:0]   sum, diff;
  logic             c_out, v_out, flag_wr, reg_wr;
  logic             unused_alu_bits;

  assign opcode          = alu_op[3:0];
  assign imm_sel         = alu_op[7];
  assign unused_alu_bits = ^alu_op[6:4];

  assign op_a = r_q[muxes[7:4]];
  assign op_b = imm_sel ? imm : r_q[muxes[3:0]];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    res     = op_a;
    c_out   = 1'b0;
    v_out   = 1'b0;
    flag_wr = 1'b1;
    reg_wr  = 1'b1;
    case (opcode)
      OP_ADD: begin
        res   = sum[MSB:0];
        c_out = sum[WIDTH];
        v_out = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res    = diff[MSB:0];
        // Carry means "no borrow", i.e. A >= B unsigned.
        c_out  = ~diff[WIDTH];
        v_out  = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
        reg_wr = (opcode == OP_SUB);
      end
      OP_AND: res = op_a & op_b;
      OP_OR:  res = op_a | op_b;
      OP_XOR: res = op_a ^ op_b;
      OP_NOT: res = ~op_a;
      OP_LSL: begin
        res   = {op_a[MSB-1:0], 1'b0};
        c_out = op_a[MSB];
      end
      OP_LSR: begin
        res   = {1'b0, op_a[MSB:1]};
        c_out = op_a[0];
      end
      OP_MOV: res = op_b;
      default: begin
        flag_wr = 1'b0;
        reg_wr  = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (en && flag_wr) begin
      flags_d = {c_out, (res == '0), res[MSB], v_out};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // One flop bank per register so a multi-hot regs_en fans the result out.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      always_comb begin
        r_d[gi] = r_q[gi];
        if (en && reg_wr && regs_en[gi]) begin
          r_d[gi] = res;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_q[gi] <= '0;
        end else begin
          r_q[gi] <= r_d[gi];
        end
      end
    end
  endgenerate

  assign result   = res;
  assign flags    = flags_q;
  assign dbg_data = r_q[dbg_sel];

endmodule
